fifo_ptr_ctrl: RTL and testbench

- Bookkeeping stage for the 8-longword DMA FIFO that sits between the SCSI byte side and the CPU bus state machine.
- Tracks the longword count, the write (in) and read (out) longword pointers, and the SCSI-side byte offset.
- Produces the FIFOFULL, FIFOEMPTY, BOEQ0 and BOEQ3 status consumed by the CPU bus state machine.
- Consumes that state machine's INCFIFO, DECFIFO, INCNI and INCNO strobes.

---
 rtl/fifo_ptr_ctrl.sv | 147 ++++++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and byte-offset bookkeeping for the DMA longword FIFO
// between the SCSI byte side and the CPU bus state machine.
module fifo_ptr_ctrl #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clrfifo_i,
    input  logic                  loadbo_i,
    input  logic                  a1_i,
    input  logic                  incbo_i,
    input  logic                  incfifo_i,
    input  logic                  decfifo_i,
    input  logic                  incni_i,
    input  logic                  incno_i,
    output logic [DEPTH_LOG2-1:0] wptr_o,
    output logic [DEPTH_LOG2-1:0] rptr_o,
    output logic [1:0]            bo_o,
    output logic [DEPTH_LOG2:0]   wcount_o,
    output logic                  fifofull_o,
    output logic                  fifoempty_o,
    output logic                  boeq0_o,
    output logic                  boeq3_o,
    output logic                  fifoerr_o
);

    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_t;

    logic [DEPTH_LOG2:0]   wcount_q, wcount_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [1:0]            bo_q, bo_d;
    logic                  err_q, err_d;
    occ_t                  occ_q, occ_d;

    logic inc_only;
    logic dec_only;

    assign inc_only = incfifo_i & ~decfifo_i;
    assign dec_only = decfifo_i & ~incfifo_i;

    always_comb begin
        wcount_d = wcount_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        bo_d     = bo_q;
        err_d    = err_q;
        occ_d    = occ_q;

        if (clrfifo_i) begin
            wcount_d = '0;
            wptr_d   = '0;
            rptr_d   = '0;
            bo_d     = '0;
            err_d    = 1'b0;
            occ_d    = OCC_EMPTY;
        end else begin
            // Over/underflow holds the count and latches the error instead.
            if (inc_only) begin
                if (occ_q == OCC_FULL) begin
                    err_d = 1'b1;
                end else begin
                    wcount_d = wcount_q + CNT_ONE;
                end
            end else if (dec_only) begin
                if (occ_q == OCC_EMPTY) begin
                    err_d = 1'b1;
                end else begin
                    wcount_d = wcount_q - CNT_ONE;
                end
            end

            if (incni_i) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (incno_i) begin
                rptr_d = rptr_q + PTR_ONE;
            end

            if (loadbo_i) begin
                bo_d = {a1_i, 1'b0};
            end else if (incbo_i) begin
                bo_d = bo_q + 2'd1;
            end

            case (occ_q)
                OCC_EMPTY: begin
                    if (inc_only) begin
                        occ_d = (wcount_d == FULL_CNT) ? OCC_FULL : OCC_PARTIAL;
                    end
                end
                OCC_PARTIAL: begin
                    if (inc_only && wcount_d == FULL_CNT) begin
                        occ_d = OCC_FULL;
                    end else if (dec_only && wcount_d == '0) begin
                        occ_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (dec_only) begin
                        occ_d = (wcount_d == '0) ? OCC_EMPTY : OCC_PARTIAL;
                    end
                end
                default: begin
                    occ_d = OCC_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wcount_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            bo_q     <= '0;
            err_q    <= 1'b0;
            occ_q    <= OCC_EMPTY;
        end else begin
            wcount_q <= wcount_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            bo_q     <= bo_d;
            err_q    <= err_d;
            occ_q    <= occ_d;
        end
    end

    assign wptr_o      = wptr_q;
    assign rptr_o      = rptr_q;
    assign bo_o        = bo_q;
    assign wcount_o    = wcount_q;
    assign fifofull_o  = (occ_q == OCC_FULL);
    assign fifoempty_o = (occ_q == OCC_EMPTY);
    assign boeq0_o     = (bo_q == 2'd0);
    assign boeq3_o     = (bo_q == 2'd3);
    assign fifoerr_o   = err_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Bench for fifo_ptr_ctrl: directed scenarios plus randomized strobes checked
// against an arithmetic model of counts, pointers and byte offset.
module tb_fifo_ptr_ctrl;

    localparam int DL = 3;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst, clrfifo, loadbo, a1, incbo, incfifo, decfifo, incni, incno;
    logic [DL-1:0] wptr, rptr;
    logic [1:0]    bo;
    logic [DL:0]   wcount;
    logic          fifofull, fifoempty, boeq0, boeq3, fifoerr;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int m_cnt, m_w, m_r, m_bo;
    bit m_err;

    always #5 clk = ~clk;

    fifo_ptr_ctrl #(.DEPTH_LOG2(DL)) dut (
        .clk_i(clk), .rst_i(rst), .clrfifo_i(clrfifo), .loadbo_i(loadbo),
        .a1_i(a1), .incbo_i(incbo), .incfifo_i(incfifo), .decfifo_i(decfifo),
        .incni_i(incni), .incno_i(incno),
        .wptr_o(wptr), .rptr_o(rptr), .bo_o(bo), .wcount_o(wcount),
        .fifofull_o(fifofull), .fifoempty_o(fifoempty), .boeq0_o(boeq0),
        .boeq3_o(boeq3), .fifoerr_o(fifoerr)
    );

    function automatic void model_reset();
        m_cnt = 0; m_w = 0; m_r = 0; m_bo = 0; m_err = 0;
    endfunction

    function automatic void model_update();
        if (rst || clrfifo) begin
            model_reset();
            return;
        end
        if (incfifo && !decfifo) begin
            if (m_cnt == D) m_err = 1; else m_cnt++;
        end else if (decfifo && !incfifo) begin
            if (m_cnt == 0) m_err = 1; else m_cnt--;
        end
        if (incni) m_w = (m_w + 1) % D;
        if (incno) m_r = (m_r + 1) % D;
        if (loadbo) m_bo = a1 ? 2 : 0;
        else if (incbo) m_bo = (m_bo + 1) % 4;
    endfunction

    task automatic idle();
        clrfifo = 0; loadbo = 0; a1 = 0; incbo = 0;
        incfifo = 0; decfifo = 0; incni = 0; incno = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        rst = 1; idle();
        tick(); tick();
        vectors++;
        if ({wcount, wptr, rptr, bo, fifoerr} !== '0) begin
            miscompares++;
            $display("FAIL reset_regs: got wcount=%0d wptr=%0d rptr=%0d bo=%0d err=%0b, want all 0",
                     wcount, wptr, rptr, bo, fifoerr);
        end
        vectors++;
        if ({fifoempty, boeq0, fifofull, boeq3} !== 4'b1100) begin
            miscompares++;
            $display("FAIL reset_flags: got empty/boeq0/full/boeq3=%b, want 1100",
                     {fifoempty, boeq0, fifofull, boeq3});
        end
        rst = 0;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= D; i++) begin
            idle(); incfifo = 1; incni = 1;
            tick();
            vectors++;
            if (wcount !== 4'(i)) begin
                miscompares++;
                $display("FAIL fill_count: step %0d got wcount=%0d want %0d", i, wcount, i);
            end
        end
        idle();
        vectors++;
        if ({fifofull, fifoempty, wptr, fifoerr} !== {2'b10, 3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL fill_end: got full=%0b empty=%0b wptr=%0d err=%0b want 1 0 0 0",
                     fifofull, fifoempty, wptr, fifoerr);
        end
    endtask

    task automatic test_overflow_drain();
        idle(); incfifo = 1;
        tick(); idle();
        vectors++;
        if (wcount !== 4'd8 || fifoerr !== 1'b1 || fifofull !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow: got wcount=%0d err=%0b full=%0b want 8 1 1", wcount, fifoerr, fifofull);
        end
        for (int i = D - 1; i >= 0; i--) begin
            idle(); decfifo = 1; incno = 1;
            tick();
            vectors++;
            if (wcount !== 4'(i) || fifofull !== 1'b0) begin
                miscompares++;
                $display("FAIL drain_count: got wcount=%0d full=%0b want %0d 0", wcount, fifofull, i);
            end
        end
        idle();
        vectors++;
        if (fifoempty !== 1'b1 || rptr !== 3'd0 || fifoerr !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_end: got empty=%0b rptr=%0d err=%0b want 1 0 1", fifoempty, rptr, fifoerr);
        end
        clrfifo = 1; incfifo = 1; incni = 1; loadbo = 1; a1 = 1;
        tick(); idle();
        vectors++;
        if (fifoerr !== 1'b0 || wcount !== 4'd0 || wptr !== 3'd0 || bo !== 2'd0) begin
            miscompares++;
            $display("FAIL clrfifo: got err=%0b wcount=%0d wptr=%0d bo=%0d want 0 0 0 0",
                     fifoerr, wcount, wptr, bo);
        end
    endtask

    task automatic test_underflow_simul();
        idle(); decfifo = 1;
        tick(); idle();
        vectors++;
        if (wcount !== 4'd0 || fifoerr !== 1'b1 || fifoempty !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow: got wcount=%0d err=%0b empty=%0b want 0 1 1", wcount, fifoerr, fifoempty);
        end
        clrfifo = 1; tick(); idle();
        incfifo = 1; decfifo = 1;
        tick(); idle();
        vectors++;
        if (wcount !== 4'd0 || fifoerr !== 1'b0 || fifoempty !== 1'b1) begin
            miscompares++;
            $display("FAIL both_at_empty: got wcount=%0d err=%0b empty=%0b want 0 0 1", wcount, fifoerr, fifoempty);
        end
        for (int i = 0; i < D; i++) begin
            incfifo = 1; tick();
        end
        incfifo = 1; decfifo = 1;
        tick(); idle();
        vectors++;
        if (wcount !== 4'd8 || fifoerr !== 1'b0 || fifofull !== 1'b1) begin
            miscompares++;
            $display("FAIL both_at_full: got wcount=%0d err=%0b full=%0b want 8 0 1", wcount, fifoerr, fifofull);
        end
        decfifo = 1; tick(); idle();
        vectors++;
        if (wcount !== 4'd7 || fifofull !== 1'b0 || fifoempty !== 1'b0) begin
            miscompares++;
            $display("FAIL leave_full: got wcount=%0d full=%0b empty=%0b want 7 0 0", wcount, fifofull, fifoempty);
        end
        clrfifo = 1; tick(); idle();
    endtask

    task automatic test_byte_offset();
        logic [1:0] want_bo [4] = '{2'd2, 2'd3, 2'd0, 2'd2};
        logic [3:0] want_fl [4] = '{4'b0000, 4'b0001, 4'b0010, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            idle();
            case (i)
                0: begin loadbo = 1; a1 = 1; end
                1: incbo = 1;
                2: incbo = 1;
                default: begin loadbo = 1; a1 = 1; incbo = 1; end
            endcase
            tick();
            vectors++;
            if (bo !== want_bo[i] || {2'b00, boeq0, boeq3} !== want_fl[i]) begin
                miscompares++;
                $display("FAIL bo_step%0d: got bo=%0d boeq0=%0b boeq3=%0b want bo=%0d flags=%b",
                         i, bo, boeq0, boeq3, want_bo[i], want_fl[i][1:0]);
            end
        end
        idle(); loadbo = 1; a1 = 0; incbo = 1;
        tick(); idle();
        vectors++;
        if (bo !== 2'd0 || boeq0 !== 1'b1) begin
            miscompares++;
            $display("FAIL bo_load0_pri: got bo=%0d boeq0=%0b want 0 1", bo, boeq0);
        end
    endtask

    task automatic test_ptr_wrap();
        idle(); clrfifo = 1; tick(); idle();
        for (int i = 0; i < D - 1; i++) begin
            incni = 1; incno = 1; tick();
        end
        vectors++;
        if (wptr !== 3'd7 || rptr !== 3'd7) begin
            miscompares++;
            $display("FAIL ptr_at7: got wptr=%0d rptr=%0d want 7 7", wptr, rptr);
        end
        incni = 1; incno = 1; tick(); idle();
        vectors++;
        if (wptr !== 3'd0 || rptr !== 3'd0 || wcount !== 4'd0) begin
            miscompares++;
            $display("FAIL ptr_wrap: got wptr=%0d rptr=%0d wcount=%0d want 0 0 0", wptr, rptr, wcount);
        end
    endtask

    task automatic test_async_reset();
        idle(); clrfifo = 1; tick(); idle();
        for (int i = 0; i < 5; i++) begin
            idle(); incfifo = 1; incni = (i < 3); tick();
        end
        idle(); loadbo = 1; a1 = 1; incfifo = 1; decfifo = 1; tick(); idle();
        vectors++;
        if (wcount !== 4'd5 || wptr !== 3'd3 || bo !== 2'd2) begin
            miscompares++;
            $display("FAIL async_setup: got wcount=%0d wptr=%0d bo=%0d want 5 3 2", wcount, wptr, bo);
        end
        #2 rst = 1;
        #1;
        vectors++;
        if ({wcount, wptr, rptr, bo, fifoerr, fifofull, boeq3} !== '0 || {fifoempty, boeq0} !== 2'b11) begin
            miscompares++;
            $display("FAIL async_reset: got wcount=%0d wptr=%0d bo=%0d empty=%0b boeq0=%0b before edge, want reset values",
                     wcount, wptr, bo, fifoempty, boeq0);
        end
        model_reset();
        #2 rst = 0;
    endtask

    task automatic test_random();
        logic [15:0] exp_v, got_v;
        idle(); clrfifo = 1; tick();
        for (int n = 0; n < 600; n++) begin
            int bias;
            bias = (n / 60) % 2;
            idle();
            clrfifo = ($urandom_range(0, 63) == 0);
            incfifo = ($urandom_range(0, 9) < (bias ? 6 : 3));
            decfifo = ($urandom_range(0, 9) < (bias ? 3 : 6));
            incni   = $urandom_range(0, 1);
            incno   = $urandom_range(0, 1);
            loadbo  = ($urandom_range(0, 7) == 0);
            a1      = $urandom_range(0, 1);
            incbo   = $urandom_range(0, 1);
            tick();
            exp_v = {4'(m_cnt), 3'(m_w), 3'(m_r), 2'(m_bo), m_cnt == D, m_cnt == 0, m_err, m_bo == 3};
            got_v = {wcount, wptr, rptr, bo, fifofull, fifoempty, fifoerr, boeq3};
            vectors++;
            if (got_v !== exp_v || boeq0 !== (m_bo == 0)) begin
                miscompares++;
                $display("FAIL random[%0d]: got cnt=%0d w=%0d r=%0d bo=%0d full=%0b empty=%0b err=%0b want cnt=%0d w=%0d r=%0d bo=%0d err=%0b",
                         n, wcount, wptr, rptr, bo, fifofull, fifoempty, fifoerr, m_cnt, m_w, m_r, m_bo, m_err);
            end
        end
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_overflow_drain();
        test_underflow_simul();
        test_byte_offset();
        test_ptr_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
